// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_pkg
// Purpose  : Shared types and default constants for the PWM capture block.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

  // Capture FSM: hunting for a frame start, measuring high time, measuring low time
  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  localparam int CAP_WIDTH  = 8;
  localparam int CAP_PERIOD = 256;
  localparam int CAP_TOL    = 2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Two-flop synchronizer for the asynchronous PWM pin, plus a delay
//            flop that turns the synchronized level into rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Synchronizer chain followed by the one-cycle delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign s    = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Recovers one WIDTH-bit sample per PWM frame from a single wire.
//            Aligns to rising edges, measures high time and frame period,
//            flags malformed frames and tracks lock.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH  = CAP_WIDTH,
  parameter int PERIOD = CAP_PERIOD,
  parameter int TOL    = CAP_TOL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] C_PER_LO  = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] C_PER_HI  = CW'(PERIOD + TOL);
  // A missing rise is noticed TOL clocks late, so the virtual frame is already TOL+1 old
  localparam logic [CW-1:0] C_RESTART = CW'(TOL + 1);

  logic s;
  logic rise;
  logic fall;

  cap_state_t       state_q, state_d;
  logic [CW-1:0]    per_q, per_d;
  logic [CW-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic [CW-1:0]    per_inc;
  logic [CW-1:0]    hi_inc;
  logic [WIDTH-1:0] hi_sat;
  logic             per_ok;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  assign per_inc = (per_q == C_MAX) ? per_q : per_q + C_ONE;
  assign hi_inc  = (hi_q == C_MAX) ? hi_q : hi_q + C_ONE;
  // Any high time of 2^WIDTH or more has the extra counter bit set and clamps to full scale
  assign hi_sat  = hi_q[WIDTH] ? {WIDTH{1'b1}} : hi_q[WIDTH-1:0];
  assign per_ok  = (per_q >= C_PER_LO) && (per_q <= C_PER_HI);

  // Frame tracking: next state, counters and output strobes
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;

    case (state_q)
      SEEK: begin
        if (rise) begin
          per_d   = C_ONE;
          hi_d    = C_ONE;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          per_d   = per_inc;
          state_d = LOW;
        end else if (per_q == C_PER_HI) begin
          // Pin stuck high: abandon the frame and re-acquire
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = SEEK;
        end else begin
          per_d = per_inc;
          if (s) begin
            hi_d = hi_inc;
          end
        end
      end

      LOW: begin
        if (rise) begin
          if (per_ok) begin
            sample_d = hi_sat;
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
          per_d   = C_ONE;
          hi_d    = C_ONE;
          state_d = HIGH;
        end else if (per_q == C_PER_HI) begin
          // No rise where one was due: treat as a zero-duty frame, keep hi_cnt as is
          if (locked_q) begin
            sample_d = '0;
            valid_d  = 1'b1;
          end
          per_d = C_RESTART;
        end else begin
          per_d = per_inc;
        end
      end

      default: begin
        state_d = SEEK;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEEK;
      per_q    <= '0;
      hi_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Self-checking bench for pwm_capture. Frames are described in a
//            table of {period, high time, expected strobes, expected sample
//            and lock at the end of the frame}; reset corners are hand-written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int NVEC = 18;

  typedef struct {
    int per;   // frame length in clocks
    int hi;    // high time in clocks
    int nv;    // sample_valid pulses seen while this frame is driven
    int ne;    // frame_err pulses seen while this frame is driven
    int smp;   // sample output at the end of the frame
    int lck;   // locked output at the end of the frame
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] sample;
  logic       sample_valid;
  logic       frame_err;
  logic       locked;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tot_v = 0;
  int tot_e = 0;
  int last_v_cyc = -1;

  vec_t tbl[NVEC];

  pwm_capture #(
    .WIDTH  (8),
    .PERIOD (256),
    .TOL    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe monitor, sampled 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    if (sample_valid === 1'b1) begin
      tot_v++;
      last_v_cyc = cyc;
    end
    if (frame_err === 1'b1) tot_e++;
    if (sample_valid === 1'b1 || frame_err === 1'b1)
      chk("valid_err_exclusive", int'(sample_valid & frame_err), 0);
  end

  // Drives one frame, pin changing on falling edges; st is the cycle of the start edge
  task automatic send_frame(input int per, input int hi, output int st);
    st = 0;
    for (int k = 0; k < per; k++) begin
      @(negedge clk);
      pwm_in = (k < hi);
      if (k == 0) st = cyc;
    end
  endtask

  initial begin
    int v0, e0, st, st_first;

    // Expected results per frame, hand-computed. Each frame's window sees the
    // report of the previous frame (3 clocks after its start edge).
    tbl[0]  = '{256,  64, 0, 0,   0, 0}; // first edge only
    tbl[1]  = '{256,  64, 1, 0,  64, 1}; // first sample, lock
    tbl[2]  = '{256,  64, 1, 0,  64, 1};
    tbl[3]  = '{256,  10, 1, 0,  64, 1};
    tbl[4]  = '{254,  10, 1, 0,  10, 1}; // closes 256-clock frame
    tbl[5]  = '{258,  10, 1, 0,  10, 1}; // closes 254 (lower bound)
    tbl[6]  = '{259,  10, 1, 0,  10, 1}; // closes 258: rise coincides with timeout, rise wins
    tbl[7]  = '{256,  10, 1, 1,   0, 0}; // 259 frame: timeout reports 0, then late rise errors
    tbl[8]  = '{256,  10, 1, 0,  10, 1}; // relock
    tbl[9]  = '{256,  64, 1, 0,  10, 1};
    tbl[10] = '{256,   0, 1, 0,   0, 1}; // zero duty: timeout reports 0 while locked
    tbl[11] = '{256,   1, 1, 0,  64, 1}; // closing rise of the virtual frame: hi_cnt still holds 64
    tbl[12] = '{256, 128, 1, 0,   1, 1};
    tbl[13] = '{256, 255, 1, 0, 128, 1};
    tbl[14] = '{256, 200, 1, 0, 255, 1};
    tbl[15] = '{310, 300, 1, 1, 200, 0}; // stuck high 300 clocks: error at per_cnt 258
    tbl[16] = '{256,  50, 0, 0, 200, 0}; // re-acquire from SEEK, no output
    tbl[17] = '{256,  50, 1, 0,  50, 1}; // recovered

    rst    = 1'b1;
    pwm_in = 1'b0;
    st_first = 0;
    repeat (3) @(negedge clk);
    chk("reset_sample", int'(sample), 0);
    chk("reset_valid",  int'(sample_valid), 0);
    chk("reset_err",    int'(frame_err), 0);
    chk("reset_locked", int'(locked), 0);
    rst = 1'b0;

    // Constant low after reset: nothing at all
    v0 = tot_v; e0 = tot_e;
    repeat (1000) @(negedge clk);
    chk("idle_valid",  tot_v - v0, 0);
    chk("idle_err",    tot_e - e0, 0);
    chk("idle_locked", int'(locked), 0);
    chk("idle_sample", int'(sample), 0);

    for (int i = 0; i < NVEC; i++) begin
      v0 = tot_v; e0 = tot_e;
      send_frame(tbl[i].per, tbl[i].hi, st);
      if (i == 0) st_first = st;
      chk($sformatf("f%0d_nvalid", i), tot_v - v0, tbl[i].nv);
      chk($sformatf("f%0d_nerr", i),   tot_e - e0, tbl[i].ne);
      chk($sformatf("f%0d_sample", i), int'(sample), tbl[i].smp);
      chk($sformatf("f%0d_locked", i), int'(locked), tbl[i].lck);
      if (i == 1) chk("first_valid_latency", last_v_cyc - st_first, 259);
    end

    // Reset in the middle of a high phase
    send_frame(256, 100, st);
    send_frame(256, 100, st);
    chk("pre_rst_sample", int'(sample), 100);
    chk("pre_rst_locked", int'(locked), 1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      pwm_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_valid",  int'(sample_valid), 0);
    chk("midrst_err",    int'(frame_err), 0);
    chk("midrst_locked", int'(locked), 0);
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);

    v0 = tot_v; e0 = tot_e;
    send_frame(256, 30, st);
    chk("post_rst_f0_nvalid", tot_v - v0, 0);
    chk("post_rst_f0_nerr",   tot_e - e0, 0);
    chk("post_rst_f0_locked", int'(locked), 0);
    chk("post_rst_f0_sample", int'(sample), 0);
    v0 = tot_v; e0 = tot_e;
    send_frame(256, 30, st);
    chk("post_rst_f1_nvalid", tot_v - v0, 1);
    chk("post_rst_f1_nerr",   tot_e - e0, 0);
    chk("post_rst_f1_sample", int'(sample), 30);
    chk("post_rst_f1_locked", int'(locked), 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
